// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, default bit period, frame width.
// Imported by both the receive and transmit paths.
package uart_pkg;

    localparam int UART_CYCLES = 10416;  // 100 MHz / 9600 baud
    localparam int DATA_BITS   = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, byte and status strobes out.
// master = the receiver, slave = the byte consumer / line driver.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 in;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (input in, output data, valid, frame_err, parity_err, busy);
    modport slave  (output in, input data, valid, frame_err, parity_err, busy);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Resets to 1 so a reset never looks like a falling edge downstream.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, sampling each bit at mid-bit.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES = UART_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_BIT  = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CYCLES / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 ferr_q, ferr_n;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_n;
    logic                 par_bad, par_bad_n;
`endif

    uart_sync u_sync (.clk(clk), .rst(rst), .d(bus.in), .q(rx_s));

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_n;
            par_bad <= par_bad_n;
`endif
        end
    end

    // Next-state, counters and strobes; counters clear on every state change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n    = 1'b0;
        par_bad_n = par_bad;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    // Still low at mid-start: real start bit, else a glitch.
                    state_n = rx_s ? S_IDLE : S_DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_BIT) begin
                    shift_n[bit_idx] = rx_s;
                    cnt_n            = '0;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                        bit_n = '0;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_BIT) begin
                    // Even parity: the XOR of data and parity bit must be 0.
                    par_bad_n = rx_s ^ (^shift);
                    state_n   = S_STOP;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n  = shift;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shift;
                        valid_n = 1'b1;
`endif
                    end else begin
                        // Bad stop bit wins over parity; wait out any break.
                        ferr_n  = 1'b1;
                        state_n = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
